// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: freezes the pipe and runs one req/ack data
// memory transaction per load/store, with a sticky timeout error.
module mem_stage_ctrl #(
  parameter int LEN_WORD    = 32,
  parameter int LEN_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [LEN_WORD-1:0] alu_out,
  input  logic [LEN_WORD-1:0] write_data_mem,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [LEN_WORD-1:0] dmem_addr,
  output logic [LEN_WORD-1:0] dmem_wdata,
  input  logic                dmem_ack,
  input  logic [LEN_WORD-1:0] dmem_rdata,
  output logic [LEN_WORD-1:0] read_data,
  output logic                stall,
  output logic                bubble,
  output logic                mem_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERROR
  } state_e;

  localparam logic [LEN_TIMEOUT-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [LEN_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [LEN_WORD-1:0]    addr_q, addr_d;
  logic [LEN_WORD-1:0]    wdata_q, wdata_d;
  logic [LEN_WORD-1:0]    rdata_q, rdata_d;
  logic                   op;

  assign op = mem_read | mem_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (op) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mem_write & ~mem_read;
          addr_d  = alu_out;
          wdata_d = write_data_mem;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERROR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // DONE deliberately releases the pipe even though EX/MEM still flags an op
  assign stall = ~reset & ((state_q == IDLE & op)
                         | (state_q == ACCESS)
                         | (state_q == ERROR));
  assign bubble     = stall;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign read_data  = rdata_q;
  assign mem_error  = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] alu_out, write_data_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data;
  logic        stall, bubble, mem_error;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  bit chk_en = 0;

  mem_stage_ctrl #(.LEN_WORD(32), .LEN_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_out(alu_out), .write_data_mem(write_data_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .read_data(read_data), .stall(stall),
    .bubble(bubble), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // Transaction view: an access is outstanding for a number of cycles,
  // completes on ack or after 16 cycles without one.
  bit          m_pend, m_done, m_err, m_we;
  int          m_age;
  logic [31:0] m_addr, m_wd, m_rd;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_done = 0; m_err = 0; m_we = 0; m_age = 0;
      m_addr = 0; m_wd = 0; m_rd = 0;
    end else if (m_err) begin
      m_err = 1;
    end else if (m_pend) begin
      if (dmem_ack) begin
        m_pend = 0;
        m_done = 1;
        if (!m_we) m_rd = dmem_rdata;
      end else if (m_age == 15) begin
        m_pend = 0;
        m_err = 1;
      end else begin
        m_age++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (mem_read || mem_write) begin
      m_pend = 1;
      m_age = 0;
      m_addr = alu_out;
      m_wd = write_data_mem;
      m_we = mem_write && !mem_read;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !reset && (m_err || m_pend ||
                (!m_done && (mem_read || mem_write)));
    if (stall) stall_cnt++;
    if (dmem_req) req_cnt++;
    if (chk_en) begin
      chk("req", {31'b0, dmem_req}, {31'b0, m_pend});
      chk("we", {31'b0, dmem_we}, {31'b0, m_we});
      chk("addr", dmem_addr, m_addr);
      chk("wdata", dmem_wdata, m_wd);
      chk("rdata", read_data, m_rd);
      chk("err", {31'b0, mem_error}, {31'b0, m_err});
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("bubble", {31'b0, bubble}, {31'b0, exp_stall});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; dmem_ack = 0;
  endtask

  initial begin
    reset = 1; idle_in();
    alu_out = 0; write_data_mem = 0; dmem_rdata = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    reset = 0;
    tick();

    // no op, with a stray ack that must be ignored
    stall_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      dmem_ack = (i == 4);
      dmem_rdata = 32'h1111_2222;
      tick();
    end
    dmem_ack = 0;
    chk("noop_stall", stall_cnt, 32'd0);
    chk("noop_req", req_cnt, 32'd0);
    chk("noop_rdata", read_data, 32'd0);

    // zero-wait load
    stall_cnt = 0; req_cnt = 0;
    mem_read = 1; alu_out = 32'h40;
    tick();
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_we", {31'b0, dmem_we}, 32'd0);
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 0;
    #1;
    chk("ld_done_rdata", read_data, 32'hDEAD_BEEF);
    chk("ld_done_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_in();
    tick();
    chk("ld_stall_cnt", stall_cnt, 32'd2);

    // store with 3 wait cycles
    stall_cnt = 0; req_cnt = 0;
    mem_write = 1; alu_out = 32'h80; write_data_mem = 32'h1234;
    repeat (4) tick();
    dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_ack = 0;
    chk("st_rdata", read_data, 32'hDEAD_BEEF);
    idle_in();
    tick();
    tick();
    chk("st_stall_cnt", stall_cnt, 32'd5);
    chk("st_req_cnt", req_cnt, 32'd4);

    // both flags: load wins, then back-to-back store
    mem_read = 1; mem_write = 1;
    alu_out = 32'h100; write_data_mem = 32'h55;
    tick();
    chk("both_we", {31'b0, dmem_we}, 32'd0);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 0;
    tick();
    mem_read = 0; mem_write = 1;
    alu_out = 32'h200; write_data_mem = 32'h77;
    #1;
    chk("b2b_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("b2b_we", {31'b0, dmem_we}, 32'd1);
    chk("b2b_addr", dmem_addr, 32'h200);
    dmem_ack = 1;
    tick();
    idle_in();
    tick();
    chk("b2b_rdata", read_data, 32'hCAFE_F00D);

    // reset mid-access, then a late ack
    mem_read = 1; alu_out = 32'h20;
    repeat (3) tick();
    reset = 1; mem_read = 0;
    tick();
    chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    reset = 0; dmem_ack = 1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_ack = 0;
    tick();
    chk("late_ack_rdata", read_data, 32'd0);
    chk("late_ack_stall", {31'b0, stall}, 32'd0);

    // preload read_data, then timeout
    mem_read = 1; alu_out = 32'h44;
    tick();
    dmem_ack = 1; dmem_rdata = 32'h0000_ABCD;
    tick();
    idle_in();
    tick();
    req_cnt = 0;
    mem_read = 1; alu_out = 32'h10;
    repeat (20) tick();
    chk("to_req_cnt", req_cnt, 32'd16);
    chk("to_err", {31'b0, mem_error}, 32'd1);
    chk("to_stall", {31'b0, stall}, 32'd1);
    chk("to_rdata", read_data, 32'h0000_ABCD);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    tick();
    chk("to_sticky", {31'b0, mem_error}, 32'd1);
    reset = 1; idle_in();
    tick();
    reset = 0;
    tick();
    chk("to_rst_err", {31'b0, mem_error}, 32'd0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
